// File: rtl/quant_pack_int8_pkg.sv
// Shared fp16 field layout, int8 clip thresholds and the packed output word for quant_pack_int8.
package quant_pack_int8_pkg;

    localparam int FP16_W     = 16;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    // Magnitude-field thresholds: 0.5, +127.5 and -128.5.
    localparam logic [FP16_W-2:0] HALF_MAG     = 15'h3800;
    localparam logic [FP16_W-2:0] POS_CLIP_MAG = 15'h57F8;
    localparam logic [FP16_W-2:0] NEG_CLIP_MAG = 15'h5804;

    localparam logic [7:0] INT8_MAX = 8'h7F;
    localparam logic [7:0] INT8_MIN = 8'h80;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } pack_word_t;

    function automatic logic fp16_clipped(input logic [FP16_W-1:0] f);
        return f[FP16_W-1] ? (f[FP16_W-2:0] >= NEG_CLIP_MAG)
                           : (f[FP16_W-2:0] >= POS_CLIP_MAG);
    endfunction

endpackage

// File: rtl/quant_pack_int8_fp16toint8.sv
// Combinational fp16 -> int8 conversion: flush below 0.5, clip at the int8 range, round half up on magnitude.
module fp16toint8
    import quant_pack_int8_pkg::*;
(
    input  logic [FP16_W-1:0] fp,
    output logic [7:0]        q
);

    logic                  sign;
    logic [FP16_EXP_W-1:0] exp_f;
    logic [FP16_MAN_W-1:0] man;
    logic [FP16_W-2:0]     mag_field;
    logic [FP16_MAN_W:0]   mant;
    logic [4:0]            shift;
    logic [7:0]            mag;

    assign sign      = fp[FP16_W-1];
    assign mag_field = fp[FP16_W-2:0];
    assign exp_f     = fp[FP16_W-2 -: FP16_EXP_W];
    assign man       = fp[FP16_MAN_W-1:0];
    assign mant      = {1'b1, man};

    // Keep one fraction bit below the integer point, add one, drop it: round half up.
    // Only meaningful for exponents 14..22, which is all the non-clipped, non-zero range reaches.
    assign shift = 5'd24 - exp_f;
    assign mag   = 8'(({1'b0, mant >> shift} + 12'd1) >> 1);

    always_comb begin
        // NOTE: q gets a default before any branch so always_comb never infers a latch.
        q = '0;
        if (fp16_clipped(fp))
            q = sign ? INT8_MIN : INT8_MAX;
        else if (mag_field < HALF_MAG)
            q = '0;
        else
            q = sign ? 8'(8'd0 - mag) : mag;
    end

endmodule

// File: rtl/quant_pack_int8.sv
// Quantises fp16 elements to int8 and packs four lanes per 32-bit word into a small output FIFO.
// Optional feature macro: QUANT_PACK_SAT_CNT_EN adds a saturating 16-bit clip counter (sat_count).
module quant_pack_int8
    import quant_pack_int8_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_data,
    input  logic              in_last,
`ifdef QUANT_PACK_SAT_CNT_EN
    output logic [15:0]       sat_count,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [3:0]        out_keep,
    output logic              out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       cur_byte;
    logic [2:0][7:0]  pack;
    logic [1:0]       cnt;
    logic             accept;
    logic             flush;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    pack_word_t       push_word;
    pack_word_t       head;
    pack_word_t       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    fp16toint8 u_conv (
        .fp (in_data),
        .q  (cur_byte)
    );

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign in_ready   = !rst && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign flush      = (cnt == 2'd3) || in_last;
    assign push       = accept && flush;
    assign pop        = out_valid && out_ready;

    always_comb begin
        push_word = '0;
        for (int i = 0; i < 3; i++)
            if (2'(i) < cnt)
                push_word.data[8*i +: 8] = pack[i];
        push_word.data[{cnt, 3'b000} +: 8] = cur_byte;
        case (cnt)
            2'd0:    push_word.keep = 4'b0001;
            2'd1:    push_word.keep = 4'b0011;
            2'd2:    push_word.keep = 4'b0111;
            default: push_word.keep = 4'b1111;
        endcase
        push_word.last = in_last;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            pack   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                if (flush) begin
                    cnt <= '0;
                end else begin
                    case (cnt)
                        2'd0:    pack[0] <= cur_byte;
                        2'd1:    pack[1] <= cur_byte;
                        default: pack[2] <= cur_byte;
                    endcase
                    cnt <= cnt + 2'd1;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; the cleared count/pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_word;
    end

    // Head is masked to zero when empty so out_* read 0 during and right after reset.
    assign head      = mem[rd_ptr];
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head.data : '0;
    assign out_keep  = out_valid ? head.keep : '0;
    assign out_last  = out_valid ? head.last : 1'b0;

`ifdef QUANT_PACK_SAT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_count <= '0;
        else if (accept && fp16_clipped(in_data) && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_quant_pack_int8.sv
// Self-checking bench for quant_pack_int8: directed corner cases plus random traffic against a real-arithmetic model.
module tb_quant_pack_int8;
    import quant_pack_int8_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
`ifdef QUANT_PACK_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    quant_pack_int8 #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
`ifdef QUANT_PACK_SAT_CNT_EN
        .sat_count (sat_count),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_popped = 0;
    int stall_cycles = 0;
    int sat_model = 0;
    logic [7:0]  bq [$];
    pack_word_t  exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Reference conversion from the numeric definition: value = (1024+man) * 2^(exp-25).
    function automatic logic [7:0] ref_conv(input logic [15:0] f);
        int  e;
        int  r;
        real mag;
        e = int'(f[14:10]);
        if (!f[15] && f[14:0] >= 15'h57F8) return 8'h7F;
        if (f[15] && f[14:0] >= 15'h5804)  return 8'h80;
        if (f[14:0] < 15'h3800)            return 8'h00;
        mag = real'(1024 + int'(f[9:0]));
        for (int k = 0; k < 25 - e; k++) mag = mag / 2.0;
        r = int'($floor(mag + 0.5));
        if (f[15]) r = -r;
        return 8'(r);
    endfunction

    function automatic logic [15:0] rand_fp16();
        logic [14:0] m;
        case ($urandom_range(0, 3))
            0:       m = 15'($urandom_range(0, 'h37FF));
            1, 2:    m = 15'($urandom_range('h3800, 'h5803));
            default: m = 15'($urandom_range('h57F8, 'h7FFF));
        endcase
        return {1'($urandom_range(0, 1)), m};
    endfunction

    task automatic model_accept(input logic [15:0] d, input logic l);
        pack_word_t w;
        bq.push_back(ref_conv(d));
        if (((!d[15] && d[14:0] >= 15'h57F8) || (d[15] && d[14:0] >= 15'h5804)) && sat_model < 65535)
            sat_model++;
        if (l || bq.size() == 4) begin
            w = '0;
            foreach (bq[i]) begin
                w.data[8*i +: 8] = bq[i];
                w.keep[i] = 1'b1;
            end
            w.last = l;
            exp_q.push_back(w);
            bq.delete();
        end
    endtask

    // Called after a rising edge; leaves in_valid high just after the accepting edge.
    task automatic send(input logic [15:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        stall_cycles += t;
        if (t >= 200) check("accept_timeout", 32'(t), 32'd0);
        else model_accept(d, l);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every word the DUT hands over must match the model's next word.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_popped++;
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("sb_data", out_data, exp_q[0].data);
                check("sb_keep", 32'(out_keep), 32'(exp_q[0].keep));
                check("sb_last", 32'(out_last), 32'(exp_q[0].last));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] held_data;
        logic [3:0]  held_keep;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_keep", 32'(out_keep), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Mixed rounding: 1.0, 5.0, -5.0, 0.5 with last.
        send(16'h3C00, 1'b0);
        send(16'h4500, 1'b0);
        send(16'hC500, 1'b0);
        send(16'h3800, 1'b1);
        @(negedge clk);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("w1_data", out_data, 32'h01FB0501);
        check("w1_keep", 32'(out_keep), 32'hF);
        check("w1_last", 32'(out_last), 32'd1);
        idle();
        drain("w1");

        // Clipping at both ends, short row.
        send(16'h7C00, 1'b0);
        send(16'h57F8, 1'b0);
        send(16'hD804, 1'b1);
        @(negedge clk);
        check("w2_data", out_data, 32'h00807F7F);
        check("w2_keep", 32'(out_keep), 32'h7);
        check("w2_last", 32'(out_last), 32'd1);
`ifdef QUANT_PACK_SAT_CNT_EN
        check("w2_sat_count", 32'(sat_count), 32'd3);
`endif
        idle();
        drain("w2");

        // Just under one half flushes to zero, single-lane row.
        send(16'h37FF, 1'b1);
        @(negedge clk);
        check("w3_data", out_data, 32'h00000000);
        check("w3_keep", 32'(out_keep), 32'h1);
        check("w3_last", 32'(out_last), 32'd1);
`ifdef QUANT_PACK_SAT_CNT_EN
        check("w3_sat_count", 32'(sat_count), 32'd3);
`endif
        idle();
        drain("w3");

        // Random traffic with random backpressure and row ends.
        for (int i = 0; i < 40; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send(rand_fp16(), ($urandom_range(0, 5) == 0));
        end
        idle();
        out_ready = 1'b1;
        send(rand_fp16(), 1'b1);
        idle();
        drain("random");
`ifdef QUANT_PACK_SAT_CNT_EN
        check("rand_sat_count", 32'(sat_count), 32'(sat_model));
`endif

        // Backpressure: FIFO fills after DEPTH words, head holds steady, nothing lost.
        out_ready = 1'b0;
        for (int i = 0; i < 4 * DEPTH; i++) send(rand_fp16(), 1'b0);
        idle();
        @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        held_data = out_data;
        held_keep = out_keep;
        check("full_head_data", held_data, exp_q[0].data);
        repeat (3) begin
            @(negedge clk);
            check("stall_data", out_data, held_data);
            check("stall_keep", 32'(out_keep), 32'(held_keep));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(rand_fp16(), (i == 3));
        idle();
        drain("backpressure");

        // Reset mid-operation: one queued word plus two pending lanes are dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(rand_fp16(), 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        exp_q.delete();
        bq.delete();
        sat_model = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        check("postrst_out_valid", 32'(out_valid), 32'd0);
`ifdef QUANT_PACK_SAT_CNT_EN
        check("postrst_sat_count", 32'(sat_count), 32'd0);
`endif
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4200, 1'b0);
        send(16'h4400, 1'b0);
        @(negedge clk);
        check("postrst_data", out_data, 32'h04030201);
        check("postrst_keep", 32'(out_keep), 32'hF);
        check("postrst_last", 32'(out_last), 32'd0);
        idle();
        drain("postrst");

        // Streaming: back-to-back accepts with no stall, one word per four elements.
        stall_cycles = 0;
        base = n_popped;
        for (int i = 0; i < 16; i++) send(rand_fp16(), 1'b0);
        idle();
        drain("stream");
        check("stream_stalls", 32'(stall_cycles), 32'd0);
        check("stream_words", 32'(n_popped - base), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/quant_pack_int8.md
QUANT_PACK_INT8 -- requirements
Module: quant_pack_int8

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output word FIFO entries (power of 2, >=2).
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, fp16 element present.
REQ-005 SHALL have port in_ready, output, 1, element accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data, input, 16, fp16 element (sign/exp5/man10).
REQ-007 SHALL have port in_last, input, 1, element ends the tensor row; forces flush.
REQ-008 SHALL have port out_valid, output, 1, packed word present.
REQ-009 SHALL have port out_ready, input, 1, word consumed when out_valid && out_ready.
REQ-010 SHALL have port out_data, output, 32, four int8 lanes, first-accepted element in [7:0].
REQ-011 SHALL have port out_keep, output, 4, per-byte valid mask.
REQ-012 SHALL have port out_last, output, 1, word closes the row.

Function
REQ-013 SHALL convert each accepted element combinationally with fp16toint8 semantics: |x|<0.5 (field <0x3800) -> 0; positive field >=0x57F8 -> 127; negative field >=0x5804 -> -128; otherwise round-half-up on magnitude, then two's complement.
REQ-014 SHALL hold a pack register (3 bytes) and byte counter cnt in 0..3, idle at 0.
REQ-015 SHALL on accept with cnt<3 and !in_last store the byte in lane cnt and increment cnt.
REQ-016 SHALL on accept with cnt==3 or in_last write {current byte, stored bytes} to the FIFO in the same cycle, keep = lanes 0..cnt set, last = in_last, unused lanes 0x00, and set cnt to 0.
REQ-017 SHALL drive in_ready = !fifo_full, with no same-cycle pop bypass.
REQ-018 SHALL drive out_valid = !fifo_empty; out_data/out_keep/out_last from FIFO head.
REQ-019 SHALL give latency of one cycle from completing accept to out_valid when the FIFO was empty.
REQ-020 SHALL support simultaneous push and pop with count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL hold out_* stable while out_valid && !out_ready.
REQ-022 SHALL keep cnt and pack register unchanged on cycles without an accept.

Reset
REQ-023 SHALL on rst asynchronously clear cnt, pack register, FIFO pointers and count; out_valid=0, out_data=0, out_keep=0, out_last=0, in_ready=0 while rst high, in_ready=1 first cycle after release.
REQ-024 SHALL discard any partial word and queued words on reset mid-operation; no flush.

Configuration
REQ-025 SHALL with QUANT_PACK_SAT_CNT_EN defined add output sat_count, 16 bits, incrementing per accepted element clipped per REQ-013 thresholds, saturating at 0xFFFF, cleared only by rst.
REQ-026 SHALL without QUANT_PACK_SAT_CNT_EN omit sat_count port and logic entirely; datapath identical.

Structure
REQ-027 SHALL place in a shared package: fp16 field widths, thresholds 0x3800/0x57F8/0x5804, INT8_MAX/INT8_MIN, packed-word struct {data, keep, last}.
REQ-028 SHALL instantiate exactly one fp16toint8 for conversion; the FIFO stays inline.

Verification
REQ-029 SHALL cover: 0x3C00, 0x4500, 0xC500, 0x3800 then last -> one word 0x01FB0501, keep 0xF, last 1.
REQ-030 SHALL cover: 0x7C00, 0x57F8, 0xD804 (last) -> data 0x00807F7F, keep 0x7, last 1, sat_count 3 when enabled.
REQ-031 SHALL cover: 0x37FF (last) -> data 0x00000000, keep 0x1; sat_count unchanged.
REQ-032 SHALL cover: out_ready held 0, 4*(FIFO_DEPTH+1) elements offered -> in_ready drops after FIFO_DEPTH words, no loss or reorder after out_ready=1.
REQ-033 SHALL cover: rst asserted after 2 accepted bytes with a queued word -> out_valid 0 immediately; next 4 elements yield a fresh word aligned at lane 0.
REQ-034 SHALL cover: continuous in_valid/out_ready=1 -> one word per 4 cycles, push and pop in the same cycle, FIFO count stable.
